// File: rtl/cunit_pkg.sv
// cunit_pkg: bus/ALU encodings, sequence-counter states and control bundle shared by cunit and dpath
package cunit_pkg;
  localparam logic [2:0] BUS_SEL_ZERO = 3'd0, BUS_SEL_AR = 3'd1, BUS_SEL_PC = 3'd2, BUS_SEL_DR = 3'd3,
                         BUS_SEL_AC = 3'd4, BUS_SEL_IR = 3'd5, BUS_SEL_TR = 3'd6, BUS_SEL_M = 3'd7;
  localparam logic [2:0] ALU_OP_PASS = 3'd0, ALU_OP_AND = 3'd1, ALU_OP_ADD = 3'd2, ALU_OP_LDA = 3'd3,
                         ALU_OP_CMA = 3'd4, ALU_OP_CIR = 3'd5, ALU_OP_CIL = 3'd6, ALU_OP_CME = 3'd7;
  typedef enum logic [2:0] {SC_T0, SC_T1, SC_T2, SC_T3, SC_T4, SC_T5, SC_T6} sc_e;
  typedef enum logic [1:0] {MODE_INIT, MODE_RUN, MODE_HALT} mode_e;
  typedef struct packed {
    logic ar_load, pc_load, dr_load, ac_load, ir_load, tr_load, outr_load, r_load;
    logic ar_reset, pc_reset, dr_reset, ac_reset, tr_reset, ien_reset, r_reset;
    logic ar_inc, pc_inc, dr_inc, ac_inc, ien_set, m_read, m_write, fgi_clr, fgo_clr;
    logic [2:0] bus_sel;
    logic [2:0] alu_ops;
  } ctrl_t;
endpackage

// File: rtl/cunit_timing_decoder.sv
// cunit_timing_decoder: sequence counter with clear, one-hot T0..T6 decode and illegal-count flag
module cunit_timing_decoder
  import cunit_pkg::*;
#(
  parameter int SC_WIDTH = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clr,
  output logic [6:0] t,
  output logic       illegal
);
  logic [SC_WIDTH-1:0] sc;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sc <= '0;
    else sc <= clr ? '0 : sc + 1'b1;
  always_comb
    for (int k = 0; k < 7; k++) t[k] = sc == SC_WIDTH'(k);
  assign illegal = sc > SC_WIDTH'(SC_T6);
endmodule

// File: rtl/cunit.sv
// cunit: hardwired control unit driving every dpath strobe for fetch, execute, I/O, interrupt and halt
module cunit
  import cunit_pkg::*;
#(
  parameter int SC_WIDTH = 3,
  parameter bit INIT_CYC = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        D0, D1, D2, D3, D4, D5, D6, D7,
  input  logic        I,
  input  logic        B0, B1, B2, B3, B4, B5, B6, B7, B8, B9, B10, B11,
  input  logic        DR_ZERO,
  input  logic [15:0] AC_out,
  input  logic        E,
  input  logic        IEN_out,
  input  logic        R_out,
  input  logic        fgi,
  input  logic        fgo,
  output logic        AR_load, PC_load, DR_load, AC_load, IR_load, TR_load, OUTR_load, R_load,
  output logic        AR_reset, PC_reset, DR_reset, AC_reset, TR_reset, IEN_reset, R_reset,
  output logic        AR_inc, PC_inc, DR_inc, AC_inc, IEN_set, M_read, M_write,
  output logic        fgi_clr, fgo_clr,
  output logic [2:0]  BUS_sel,
  output logic [2:0]  ALU_ops,
  output logic        halted
);
  mode_e mode, mode_nx;
  ctrl_t c;
  logic [6:0] t;
  logic ill, sc_clr, skip;
  logic [2:0] rr_op;

  cunit_timing_decoder #(.SC_WIDTH(SC_WIDTH)) u_td (
    .clock(clock), .reset_n(reset_n), .clr(sc_clr), .t(t), .illegal(ill)
  );

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) mode <= INIT_CYC ? MODE_INIT : MODE_RUN;
    else mode <= mode_nx;

  assign rr_op = B9 ? ALU_OP_CMA : B7 ? ALU_OP_CIR : B6 ? ALU_OP_CIL :
                 (B8 | (B10 & E)) ? ALU_OP_CME : ALU_OP_PASS;
  assign skip = (B4 & ~AC_out[15]) | (B3 & AC_out[15]) | (B2 & ~|AC_out) | (B1 & ~E);

  always_comb begin
    c = '0;
    mode_nx = mode;
    sc_clr = 1'b0;
    if (mode == MODE_INIT) begin
      {c.ar_reset, c.pc_reset, c.dr_reset, c.ac_reset, c.tr_reset, c.ien_reset, c.r_reset} = 7'h7F;
      sc_clr = 1'b1;
      mode_nx = MODE_RUN;
    end else if (mode == MODE_HALT || ill) begin
      sc_clr = 1'b1;
    end else if (R_out && |t[2:0]) begin
      c.ar_reset = t[0];
      c.tr_load = t[0];
      c.bus_sel = t[0] ? BUS_SEL_PC : t[1] ? BUS_SEL_TR : BUS_SEL_ZERO;
      c.m_write = t[1];
      c.pc_reset = t[1];
      {c.pc_inc, c.ien_reset, c.r_reset, sc_clr} = {4{t[2]}};
    end else begin
      c.r_load = ~|t[2:0] & IEN_out & (fgi | fgo) & ~R_out;
      if (t[0]) begin
        c.bus_sel = BUS_SEL_PC;
        c.ar_load = 1'b1;
      end else if (t[1]) begin
        c.bus_sel = BUS_SEL_M;
        {c.m_read, c.ir_load, c.pc_inc} = 3'b111;
      end else if (t[2]) begin
        c.bus_sel = BUS_SEL_IR;
        c.ar_load = 1'b1;
      end else if (t[3]) begin
        sc_clr = D7;
        if (D7 && !I) begin
          // AC must load to capture a rotate/complement; CME alone only changes E
          c.ac_reset = B11;
          c.alu_ops = rr_op;
          c.ac_load = B9 | B7 | B6;
          c.ac_inc = B5 & (rr_op == ALU_OP_PASS);
          c.pc_inc = skip;
          mode_nx = B0 ? MODE_HALT : mode;
        end else if (D7) begin
          c.bus_sel = B10 ? BUS_SEL_AC : BUS_SEL_ZERO;
          c.outr_load = B10;
          c.fgo_clr = B10;
          c.pc_inc = (B9 & fgi) | (B8 & fgo);
          c.ien_set = B7;
          c.ien_reset = B6;
        end else if (I) begin
          c.bus_sel = BUS_SEL_M;
          c.m_read = 1'b1;
          c.ar_load = 1'b1;
        end
      end else if (t[4]) begin
        c.bus_sel = (D0 | D1 | D2 | D6) ? BUS_SEL_M : D3 ? BUS_SEL_AC : D4 ? BUS_SEL_AR :
                    D5 ? BUS_SEL_PC : BUS_SEL_ZERO;
        c.m_read = D0 | D1 | D2 | D6;
        c.dr_load = D0 | D1 | D2 | D6;
        c.m_write = D3 | D5;
        c.pc_load = D4;
        c.ar_inc = D5;
        sc_clr = D3 | D4;
      end else if (t[5]) begin
        c.alu_ops = D0 ? ALU_OP_AND : D1 ? ALU_OP_ADD : D2 ? ALU_OP_LDA : ALU_OP_PASS;
        c.ac_load = D0 | D1 | D2;
        c.bus_sel = D5 ? BUS_SEL_AR : BUS_SEL_ZERO;
        c.pc_load = D5;
        c.dr_inc = D6;
        sc_clr = D0 | D1 | D2 | D5;
      end else if (t[6]) begin
        c.bus_sel = D6 ? BUS_SEL_DR : BUS_SEL_ZERO;
        c.m_write = D6;
        c.pc_inc = D6 & DR_ZERO;
        sc_clr = D6;
      end
    end
  end

  assign {AR_load, PC_load, DR_load, AC_load, IR_load, TR_load, OUTR_load, R_load,
          AR_reset, PC_reset, DR_reset, AC_reset, TR_reset, IEN_reset, R_reset,
          AR_inc, PC_inc, DR_inc, AC_inc, IEN_set, M_read, M_write, fgi_clr, fgo_clr,
          BUS_sel, ALU_ops} = reset_n ? c : '0;
  assign halted = mode == MODE_HALT;
endmodule
